// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
//   Pipeline stage register with a valid/ready handshake and a two-entry skid
//   buffer. in_ready is derived only from registered state (plus flush/reset),
//   so back-pressure from downstream never forms a combinational path back to
//   upstream. Flush discards held beats and parks default_data (e.g. a NOP) on
//   out_data. A saturating counter records cycles stalled by downstream.
//
//   Ports:
//     clk, reset     rising-edge clock, synchronous active-high reset
//     flush          discard held entries, out_data <= default_data
//     default_data   value loaded into both registers on flush
//     in_valid/in_ready/in_data     upstream handshake and payload
//     out_valid/out_ready/out_data  downstream handshake and payload
//     occupancy      entries held (0, 1 or 2)
//     stall_count    saturating count of out_valid & ~out_ready cycles
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   EMPTY | nothing held; out_data keeps last/default/zero value
//   ONE   | main holds the head beat, skid unused
//   TWO   | main holds the head beat, skid holds the next; in_ready = 0
module pipe_stage_skid #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] default_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occupancy,
  output logic [CNT_WIDTH-1:0]  stall_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] main_q, main_nxt;
  logic [DATA_WIDTH-1:0] skid_q, skid_nxt;
  logic                  in_fire, out_fire;

  assign out_valid = (state != EMPTY);
  assign in_ready  = (state != TWO) & ~flush & ~reset;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_data  = main_q;
  assign occupancy = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state  <= state_nxt;
      main_q <= main_nxt;
      skid_q <= skid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    if (flush) begin
      // An out_fire this cycle still completes downstream; only held
      // entries are dropped.
      state_nxt = EMPTY;
      main_nxt  = default_data;
      skid_nxt  = default_data;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state_nxt = ONE;
            main_nxt  = in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_nxt = in_data;
          end else if (in_fire) begin
            state_nxt = TWO;
            skid_nxt  = in_data;
          end else if (out_fire) begin
            state_nxt = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_nxt = ONE;
            main_nxt  = skid_q;
          end
        end
        default: begin
          state_nxt = EMPTY;
        end
      endcase
    end
  end

  // Counts stalls even in a flush cycle; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
    end else if (out_valid && !out_ready && (stall_count != {CNT_WIDTH{1'b1}})) begin
      stall_count <= stall_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid
//   Scoreboard bench: the driver pushes each accepted beat into a queue, the
//   monitor pops on every downstream transfer. The queue itself is the
//   reference model (its length is the expected occupancy).
`timescale 1ns/1ps
module tb_pipe_stage_skid;
  localparam int DW  = 32;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic          clk;
  logic          reset;
  logic          flush;
  logic [DW-1:0] default_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_count;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] empty_val = '0;
  int            mstall = 0;
  bit            mv = 0;

  pipe_stage_skid #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .default_data (default_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .occupancy    (occupancy),
    .stall_count  (stall_count)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus. out_ready is first driven inverted to show
  // in_ready does not move with it, then set to its real value.
  task automatic cyc(input bit v, input logic [DW-1:0] d, input bit r,
                     input bit f = 0, input bit rs = 0,
                     input logic [DW-1:0] dd = 32'h0000_0013);
    logic ir_alt;
    @(posedge clk);
    #1;
    in_valid     = v;
    in_data      = d;
    flush        = f;
    reset        = rs;
    default_data = dd;
    out_ready    = ~r;
    #1;
    ir_alt    = in_ready;
    out_ready = r;
    #2;
    chk("ready_vs_out_ready", in_ready, ir_alt);
    #1;
    if (in_valid && in_ready) exp_q.push_back(in_data);
  endtask

  // Monitor: compares state-level outputs mid-cycle, pops at the falling edge.
  initial begin
    logic [DW-1:0] got;
    forever begin
      @(posedge clk);
      #4;
      chk("occupancy", occupancy, 32'(exp_q.size()));
      chk("out_valid", out_valid, exp_q.size() != 0);
      chk("in_ready", in_ready, (exp_q.size() < 2) && !flush && !reset);
      chk("stall_count", stall_count, 32'(mstall));
      if (exp_q.size() == 0) chk("out_data_idle", out_data, empty_val);
      else                   chk("out_data_head", out_data, exp_q[0]);
      mv = (exp_q.size() != 0);
      @(negedge clk);
      if (out_valid && out_ready && !reset) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_beat", out_valid, 1'b0);
        end else begin
          got = exp_q.pop_front();
          chk("out_beat", out_data, got);
          empty_val = got;
        end
      end
      if (reset) begin
        exp_q.delete();
        empty_val = '0;
        mstall    = 0;
      end else begin
        if (flush) begin
          exp_q.delete();
          empty_val = default_data;
        end
        if (mv && !out_ready && mstall < SAT) mstall++;
      end
    end
  end

  initial begin
    logic [DW-1:0] pay;
    reset        = 1'b1;
    flush        = 1'b0;
    default_data = '0;
    in_valid     = 1'b0;
    in_data      = '0;
    out_ready    = 1'b0;
    repeat (3) cyc(0, 0, 0, 0, 1);
    chk("reset_occupancy", occupancy, 0);
    chk("reset_stall", stall_count, 0);

    // 1: streaming at one beat per cycle, 1-cycle latency
    cyc(0, 0, 1);
    cyc(1, 32'h11, 1);
    chk("t1_latency_valid", out_valid, 0);
    cyc(1, 32'h22, 1);
    chk("t1_valid", out_valid, 1);
    chk("t1_d0", out_data, 32'h11);
    cyc(1, 32'h33, 1);
    chk("t1_d1", out_data, 32'h22);
    chk("t1_occ", occupancy, 1);
    chk("t1_ready", in_ready, 1);
    cyc(0, 0, 1);
    chk("t1_d2", out_data, 32'h33);
    cyc(0, 0, 1);
    chk("t1_empty", occupancy, 0);

    // 2: fill skid, drain in order
    cyc(1, 32'hA0, 0);
    cyc(1, 32'hB0, 0);
    chk("t2_one", occupancy, 1);
    cyc(0, 0, 1);
    chk("t2_two", occupancy, 2);
    chk("t2_not_ready", in_ready, 0);
    chk("t2_first", out_data, 32'hA0);
    cyc(0, 0, 1);
    chk("t2_second", out_data, 32'hB0);
    cyc(0, 0, 0);
    chk("t2_drained", occupancy, 0);

    // 3: flush from TWO
    cyc(1, 32'h1, 0);
    cyc(1, 32'h2, 0);
    cyc(1, 32'h99, 0, 1, 0, 32'h0000_0013);
    chk("t3_flush_ready", in_ready, 0);
    cyc(0, 0, 0);
    chk("t3_occ", occupancy, 0);
    chk("t3_valid", out_valid, 0);
    chk("t3_nop", out_data, 32'h0000_0013);

    // 4: stall counter, saturation, flush leaves it alone
    repeat (2) cyc(0, 0, 0, 0, 1);
    cyc(1, 32'h77, 0);
    repeat (11) cyc(0, 0, 0);
    chk("t4_stall10", stall_count, 10);
    repeat (25) cyc(0, 0, 0);
    chk("t4_sat", stall_count, SAT);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0);
    chk("t4_after_flush", stall_count, SAT);

    // 5: reset overrides flush in TWO
    cyc(1, 32'h1, 0);
    cyc(1, 32'h2, 0);
    cyc(0, 0, 0);
    chk("t5_two", occupancy, 2);
    cyc(1, 32'h66, 1, 1, 1, 32'h0000_0013);
    chk("t5_reset_ready", in_ready, 0);
    cyc(0, 0, 0);
    chk("t5_occ", occupancy, 0);
    chk("t5_data", out_data, 0);
    chk("t5_stall", stall_count, 0);
    cyc(1, 32'h55, 1);
    chk("t5_latency", out_valid, 0);
    cyc(0, 0, 1);
    chk("t5_valid", out_valid, 1);
    chk("t5_beat", out_data, 32'h55);

    // 6: random traffic, incrementing payload, occasional flush/reset
    pay = 32'h1000;
    for (int i = 0; i < 10000; i++) begin
      cyc($urandom_range(0, 1), pay, $urandom_range(0, 1),
          $urandom_range(0, 63) == 0, $urandom_range(0, 999) == 0, $urandom);
      if (in_valid && in_ready) pay++;
    end
    repeat (4) cyc(0, 0, 1);
    chk("t6_final_empty", occupancy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
